// File: rtl/bin2dec_seq_arb.sv
// Two-requester binary-to-BCD converter using sequential double dabble.
// A round-robin arbiter picks one operand per conversion; results saturate above 999999.
module bin2dec_seq_arb #(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [1:0]       iReq,
    input  logic [WIDTH-1:0] iData0,
    input  logic [WIDTH-1:0] iData1,
    output logic [1:0]       oAck,
    output logic             oBusy,
    output logic             oValid,
    output logic             oSrc,
    output logic [3:0]       oHunThousand,
    output logic [3:0]       oTenThousand,
    output logic [3:0]       oThousands,
    output logic [3:0]       oHundreds,
    output logic [3:0]       oTens,
    output logic [3:0]       oOnes,
    output logic             oOvf,
    output logic [1:0]       oDbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [23:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             src_q, src_d;
    logic [1:0]       ack_q, ack_d;
    logic [23:0]      res_dig_q, res_dig_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_src_q, res_src_d;

    logic [23:0]      adj;
    logic             win;

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        adj = dig_q;
        for (int k = 0; k < 6; k++) begin
            if (dig_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Single request wins outright; a tie goes to the round-robin pointer.
    assign win = (iReq == 2'b11) ? ptr_q : iReq[1];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sr_d      = sr_q;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        ack_d     = 2'b00;
        res_dig_d = res_dig_q;
        res_ovf_d = res_ovf_q;
        res_src_d = res_src_q;
        case (state_q)
            IDLE: begin
                if (iReq != 2'b00) begin
                    sr_d    = win ? iData1 : iData0;
                    dig_d   = 24'd0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    src_d   = win;
                    ptr_d   = ~win;
                    ack_d   = win ? 2'b10 : 2'b01;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                dig_d = {adj[22:0], sr_q[WIDTH-1]};
                ovf_d = ovf_q | adj[23];
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - CW'(1);
                // Results are published from the final step's next-state values.
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    res_dig_d = ovf_d ? 24'h999999 : dig_d;
                    res_ovf_d = ovf_d;
                    res_src_d = src_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            sr_q      <= '0;
            dig_q     <= 24'd0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            ack_q     <= 2'b00;
            res_dig_q <= 24'd0;
            res_ovf_q <= 1'b0;
            res_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sr_q      <= sr_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            ack_q     <= ack_d;
            res_dig_q <= res_dig_d;
            res_ovf_q <= res_ovf_d;
            res_src_q <= res_src_d;
        end
    end

    assign oAck         = ack_q;
    assign oBusy        = (state_q != IDLE);
    assign oValid       = (state_q == DONE);
    assign oSrc         = res_src_q;
    assign oOvf         = res_ovf_q;
    assign oHunThousand = res_dig_q[23:20];
    assign oTenThousand = res_dig_q[19:16];
    assign oThousands   = res_dig_q[15:12];
    assign oHundreds    = res_dig_q[11:8];
    assign oTens        = res_dig_q[7:4];
    assign oOnes        = res_dig_q[3:0];
    assign oDbgState    = state_q;

endmodule

// File: tb/tb_bin2dec_seq_arb.sv
// Bench for bin2dec_seq_arb: transaction-level timeline model checked every cycle,
// plus directed conversions with hand-computed literal results.
module tb_bin2dec_seq_arb;

    localparam int W = 32;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic [1:0]    iReq = 2'b00;
    logic [W-1:0]  iData0 = '0;
    logic [W-1:0]  iData1 = '0;
    logic [1:0]    oAck;
    logic          oBusy, oValid, oSrc, oOvf;
    logic [3:0]    oHunThousand, oTenThousand, oThousands, oHundreds, oTens, oOnes;
    logic [1:0]    oDbgState;
    logic [23:0]   dut_dig;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bin2dec_seq_arb #(.WIDTH(W)) dut (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iData0(iData0), .iData1(iData1),
        .oAck(oAck), .oBusy(oBusy), .oValid(oValid), .oSrc(oSrc),
        .oHunThousand(oHunThousand), .oTenThousand(oTenThousand), .oThousands(oThousands),
        .oHundreds(oHundreds), .oTens(oTens), .oOnes(oOnes), .oOvf(oOvf),
        .oDbgState(oDbgState)
    );

    assign dut_dig = {oHunThousand, oTenThousand, oThousands, oHundreds, oTens, oOnes};

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {ovf, six BCD digits} from plain decimal arithmetic.
    function automatic logic [24:0] bcd_of(input logic [31:0] v);
        logic [24:0] r;
        longint unsigned tmp;
        r = '0;
        if (v > 32'd999999) begin
            r = {1'b1, 24'h999999};
        end else begin
            tmp = longint'(v);
            for (int k = 0; k < 6; k++) begin
                r[4*k +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
        end
        return r;
    endfunction

    // Timeline model: t = cycles since accept edge, -1 when idle.
    logic [25:0] exp_q[$];
    logic [25:0] exp_res   = '0;
    logic [1:0]  exp_ack   = 2'b00;
    logic        exp_busy  = 1'b0;
    logic        exp_valid = 1'b0;
    int          t         = -1;
    logic        ptr       = 1'b0;

    always @(posedge iCLK) begin
        logic mw;
        logic acc;
        cyc++;
        acc = 1'b0;
        mw  = 1'b0;
        if (iRST) begin
            t = -1;
            ptr = 1'b0;
            exp_q.delete();
            exp_res = '0;
        end else if (t < 0) begin
            if (iReq != 2'b00) begin
                mw = (iReq == 2'b11) ? ptr : iReq[1];
                exp_q.push_back({mw, bcd_of(mw ? iData1 : iData0)});
                ptr = ~mw;
                t = 0;
                acc = 1'b1;
            end
        end else begin
            t++;
            if (t == W && exp_q.size() > 0) exp_res = exp_q.pop_front();
            if (t > W) t = -1;
        end
        exp_ack   = acc ? (mw ? 2'b10 : 2'b01) : 2'b00;
        exp_busy  = (t >= 0);
        exp_valid = (t == W);
    end

    always @(negedge iCLK) begin
        check("ack", {30'd0, oAck}, {30'd0, exp_ack});
        check("busy", {31'd0, oBusy}, {31'd0, exp_busy});
        check("valid", {31'd0, oValid}, {31'd0, exp_valid});
        check("result", {6'd0, oSrc, oOvf, dut_dig}, {6'd0, exp_res});
    end

    task automatic wait_ack(input int idx, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge iCLK);
            if (oAck[idx]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: requester %0d got no ack within 200 cycles", idx);
        end
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge iCLK);
            if (oValid) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: no oValid within 200 cycles");
        end
    endtask

    task automatic conv(input string name, input int idx, input logic [31:0] d,
                        input logic [25:0] lit);
        int a, v;
        @(negedge iCLK);
        if (idx == 1) iData1 = d; else iData0 = d;
        iReq[idx] = 1'b1;
        wait_ack(idx, a);
        iReq[idx] = 1'b0;
        wait_valid(v);
        if (a >= 0 && v >= 0) check({name, "_latency"}, 32'(v - a), 32'(W));
        check(name, {6'd0, oSrc, oOvf, dut_dig}, {6'd0, lit});
    endtask

    initial begin
        int a0, a1, v0, v1, r, nvalid;
        repeat (3) @(negedge iCLK);
        check("reset_outputs", {16'd0, oAck, oBusy, oValid, oSrc, oOvf, 10'd0},
              32'd0);
        check("reset_digits", {8'd0, dut_dig}, 32'd0);
        iRST = 1'b0;

        conv("c123456", 0, 32'd123456, {1'b0, 1'b0, 24'h123456});
        conv("c0", 0, 32'd0, {1'b0, 1'b0, 24'h000000});
        conv("c999999", 1, 32'd999999, {1'b1, 1'b0, 24'h999999});
        conv("c1000000", 0, 32'd1000000, {1'b0, 1'b1, 24'h999999});
        conv("cffffffff", 1, 32'hFFFFFFFF, {1'b1, 1'b1, 24'h999999});
        conv("c65535", 1, 32'd65535, {1'b1, 1'b0, 24'h065535});
        conv("c100000", 0, 32'd100000, {1'b0, 1'b0, 24'h100000});
        conv("c9", 1, 32'd9, {1'b1, 1'b0, 24'h000009});
        conv("c1048575", 0, 32'd1048575, {1'b0, 1'b1, 24'h999999});

        // Both requesting through reset release: round-robin order and spacing.
        @(negedge iCLK);
        iRST = 1'b1;
        iReq = 2'b11;
        iData0 = 32'd42;
        iData1 = 32'd7;
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        r = cyc;
        wait_ack(0, a0);
        check("held_through_reset_accept", 32'(a0 - r), 32'd1);
        wait_valid(v0);
        check("tie_first", {6'd0, oSrc, oOvf, dut_dig}, {6'd0, 1'b0, 1'b0, 24'h000042});
        wait_ack(1, a1);
        iReq = 2'b00;
        check("tie_spacing", 32'(a1 - a0), 32'(W + 2));
        wait_valid(v1);
        check("tie_second", {6'd0, oSrc, oOvf, dut_dig}, {6'd0, 1'b1, 1'b0, 24'h000007});

        // Reset during SHIFT aborts the conversion.
        @(negedge iCLK);
        iData0 = 32'd555;
        iReq = 2'b01;
        wait_ack(0, a0);
        iReq = 2'b00;
        repeat (9) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        check("abort_outputs", {16'd0, oAck, oBusy, oValid, oSrc, oOvf, 10'd0}, 32'd0);
        check("abort_digits", {8'd0, dut_dig}, 32'd0);
        iRST = 1'b0;
        nvalid = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oValid) nvalid++;
        end
        check("abort_no_valid", 32'(nvalid), 32'd0);
        conv("after_abort", 1, 32'd314159, {1'b1, 1'b0, 24'h314159});

        // Operand change and late request during SHIFT.
        @(negedge iCLK);
        iData0 = 32'd271828;
        iReq = 2'b01;
        wait_ack(0, a0);
        iReq = 2'b00;
        iData0 = 32'd999;
        repeat (5) @(negedge iCLK);
        iData1 = 32'd88;
        iReq[1] = 1'b1;
        wait_valid(v0);
        check("captured_operand", {6'd0, oSrc, oOvf, dut_dig}, {6'd0, 1'b0, 1'b0, 24'h271828});
        wait_ack(1, a1);
        iReq = 2'b00;
        check("late_req_accept", 32'(a1 - v0), 32'd2);
        wait_valid(v1);
        check("late_req_result", {6'd0, oSrc, oOvf, dut_dig}, {6'd0, 1'b1, 1'b0, 24'h000088});

        repeat (3) @(negedge iCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
